// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/onehot_enc8.sv
// 8-bit one-hot to 3-bit binary encoder; an all-zero input encodes to 0.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] oh,
    output logic [IDX_W-1:0] idx
);

    // OR together the indices of all set bits (exactly one for a legal input)
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with hold-time preemption.
// Registered one-hot grant plus binary owner index; the grant is held
// until the owner drops its request or, under contention, until it has
// held for MAX_HOLD cycles.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             arb_en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pre_q, pre_d;

    logic [N_REQ-1:0]   cand;
    logic [2*N_REQ-1:0] dbl_sh;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   win_off;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;
    logic               any_cand;
    logic               holder_req;

    // Candidates: in BUSY the current holder is excluded so a handover
    // always picks someone else
    always_comb begin
        cand = (state_q == BUSY) ? (req & ~gnt_q) : req;
    end

    // Rotate so ptr lands at bit 0, then take the lowest set bit
    always_comb begin
        dbl_sh   = {cand, cand} >> ptr_q;
        rot      = dbl_sh[N_REQ-1:0];
        win_off  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) win_off = IDX_W'(i);
        end
        win_idx  = ptr_q + win_off;
        win_oh   = N_REQ'(1) << win_idx;
        any_cand = |cand;
    end

    // Holder still asserting its request
    always_comb begin
        holder_req = |(req & gnt_q);
    end

    // Next-state: grant / release / preempt / hold
    always_comb begin
        logic do_grant;
        do_grant = 1'b0;
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        pre_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_en && any_cand) do_grant = 1'b1;
            end
            BUSY: begin
                if (!holder_req) begin
                    // release wins over preemption
                    if (arb_en && any_cand) begin
                        do_grant = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (arb_en && any_cand && (cnt_q == CNT_LAST)) begin
                    do_grant = 1'b1;
                    pre_d    = 1'b1;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        if (do_grant) begin
            gnt_d   = win_oh;
            ptr_d   = win_idx + 1'b1;
            cnt_d   = '0;
            state_d = BUSY;
        end
    end

    // Index computed from the next grant so it registers alongside it
    onehot_enc8 u_enc (
        .oh  (gnt_d),
        .idx (idx_d)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;
    assign preempt   = pre_q;

endmodule
